inst_fetch: RTL and testbench

Instruction-fetch stage: owns the architectural fetch PC, issues one 32-bit instruction read at a time to the memory controller, and writes each fetched instruction with its PC and a static branch-prediction bit into the instruction queue. It sits directly upstream of the instruction queue and downstream of the memory controller. It accepts a redirect (`clear_i` plus a target) from the branch-resolution and commit logic.

---
 rtl/inst_fetch.sv | 195 +++++++++++++++++++
 tb/tb_inst_fetch.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//
// Instruction-fetch stage. Owns the architectural fetch PC and issues one
// 32-bit instruction read at a time to the memory controller. Each completed
// fetch is written into the instruction queue together with its PC and a
// static branch-prediction bit. A redirect (clear_i + clear_pc_i) from the
// branch-resolution / commit logic replaces the fetch PC and discards any
// fetch that is still in flight.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   rdy          global ready; when low all state and outputs hold
//   clear_i      redirect / flush, same cycle as the queue's clear
//   clear_pc_i   redirect target PC
//   full_i       queue full (queue keeps 2 slots of slack)
//   mc_req_o     fetch request to the memory controller
//   mc_addr_o    fetch address
//   mc_done_i    1-cycle pulse, mc_inst_i valid
//   mc_inst_i    fetched instruction word
//   we_o         queue write strobe (1-cycle pulse)
//   inst_o       instruction to the queue
//   pc_o         PC of inst_o
//   bp_o         1 = predicted taken
//
// Static predictor: JAL is always taken, conditional branches are taken when
// their offset is negative (backward), everything else (including JALR)
// falls through to PC + 4.
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear_i,
    input  logic [31:0] clear_pc_i,
    input  logic        full_i,
    output logic        mc_req_o,
    output logic [31:0] mc_addr_o,
    input  logic        mc_done_i,
    input  logic [31:0] mc_inst_i,
    output logic        we_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        bp_o
);

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // IDLE : no request outstanding, may issue when the queue has room
    // BUSY : request outstanding, its data will be written to the queue
    // FLUSH: request outstanding, but a redirect arrived; its data is dropped
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;

    logic        req_n;
    logic [31:0] addr_n;
    logic        we_n;
    logic [31:0] inst_n;
    logic [31:0] pc_out_n;
    logic        bp_n;

    // -------------------------------------------------------------------------
    // Static predictor, decoded from the returning word. mc_addr_o is still the
    // address of that word on the done cycle, so it serves as the fetch PC.
    // -------------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [31:0] j_imm;
    logic [31:0] b_imm;
    logic        pred_taken;
    logic [31:0] pred_next;

    always_comb begin
        opcode = mc_inst_i[6:0];
        j_imm  = {{12{mc_inst_i[31]}}, mc_inst_i[19:12], mc_inst_i[20],
                  mc_inst_i[30:21], 1'b0};
        b_imm  = {{20{mc_inst_i[31]}}, mc_inst_i[7], mc_inst_i[30:25],
                  mc_inst_i[11:8], 1'b0};

        pred_taken = 1'b0;
        pred_next  = mc_addr_o + 32'd4;

        if (opcode == OP_JAL) begin
            pred_taken = 1'b1;
            pred_next  = mc_addr_o + j_imm;
        end else if (opcode == OP_BRANCH && mc_inst_i[31]) begin
            // Sign bit of the B-immediate set: backward branch, assume a loop.
            pred_taken = 1'b1;
            pred_next  = mc_addr_o + b_imm;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state / next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_n  = state;
        pc_n     = pc;
        req_n    = mc_req_o;
        addr_n   = mc_addr_o;
        we_n     = 1'b0;
        inst_n   = inst_o;
        pc_out_n = pc_o;
        bp_n     = bp_o;

        case (state)
            IDLE: begin
                if (clear_i) begin
                    pc_n = clear_pc_i;
                end else if (!full_i) begin
                    req_n   = 1'b1;
                    addr_n  = pc;
                    state_n = BUSY;
                end
            end

            BUSY: begin
                if (mc_done_i && !clear_i) begin
                    req_n    = 1'b0;
                    we_n     = 1'b1;
                    inst_n   = mc_inst_i;
                    pc_out_n = mc_addr_o;
                    bp_n     = pred_taken;
                    pc_n     = pred_next;
                    state_n  = IDLE;
                end else if (mc_done_i && clear_i) begin
                    req_n   = 1'b0;
                    pc_n    = clear_pc_i;
                    state_n = IDLE;
                end else if (clear_i) begin
                    // The controller cannot abort, so the request stays up and
                    // the eventual data is discarded in FLUSH.
                    pc_n    = clear_pc_i;
                    state_n = FLUSH;
                end
            end

            FLUSH: begin
                // A newer redirect always wins, even on the done cycle.
                if (clear_i) begin
                    pc_n = clear_pc_i;
                end
                if (mc_done_i) begin
                    req_n   = 1'b0;
                    state_n = IDLE;
                end
            end

            default: begin
                req_n   = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers. rst beats rdy so a stalled pipeline can
    // still be reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            mc_req_o  <= 1'b0;
            mc_addr_o <= 32'h0;
            we_o      <= 1'b0;
            inst_o    <= 32'h0;
            pc_o      <= 32'h0;
            bp_o      <= 1'b0;
        end else if (rdy) begin
            state     <= state_n;
            pc        <= pc_n;
            mc_req_o  <= req_n;
            mc_addr_o <= addr_n;
            we_o      <= we_n;
            inst_o    <= inst_n;
            pc_o      <= pc_out_n;
            bp_o      <= bp_n;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//
// Self-checking bench for inst_fetch. A stimulus process plays the memory
// controller and the redirect source, and keeps a reference model of the
// fetch PC. Every fetch that should reach the queue is pushed into a
// scoreboard; a separate monitor pops and compares on each accepted write.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] JAL16    = 32'h0100_006F;
    localparam logic [31:0] JAL8     = 32'h0080_006F;
    localparam logic [31:0] BEQ_M8   = 32'hFE00_0CE3;
    localparam logic [31:0] BEQ_P8   = 32'h0000_0463;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        clear_i;
    logic [31:0] clear_pc_i;
    logic        full_i;
    logic        mc_req_o;
    logic [31:0] mc_addr_o;
    logic        mc_done_i;
    logic [31:0] mc_inst_i;
    logic        we_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        bp_o;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        bp;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_pc;
    int          checks;
    int          errors;

    inst_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .clear_i    (clear_i),
        .clear_pc_i (clear_pc_i),
        .full_i     (full_i),
        .mc_req_o   (mc_req_o),
        .mc_addr_o  (mc_addr_o),
        .mc_done_i  (mc_done_i),
        .mc_inst_i  (mc_inst_i),
        .we_o       (we_o),
        .inst_o     (inst_o),
        .pc_o       (pc_o),
        .bp_o       (bp_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference predictor: immediates rebuilt as signed integers from the
    // instruction fields, then added to the fetch address modulo 2^32.
    function automatic void predict(input logic [31:0] inst, input logic [31:0] addr,
                                    output logic bp, output logic [31:0] next);
        longint imm;
        if (inst[6:0] == 7'h6F) begin
            imm = longint'(inst[30:21]) * 2 + longint'(inst[20]) * 2048
                + longint'(inst[19:12]) * 4096 - (inst[31] ? 64'sd1048576 : 64'sd0);
            bp  = 1'b1;
        end else if (inst[6:0] == 7'h63 && inst[31]) begin
            imm = longint'(inst[11:8]) * 2 + longint'(inst[30:25]) * 32
                + longint'(inst[7]) * 2048 - 4096;
            bp  = 1'b1;
        end else begin
            imm = 4;
            bp  = 1'b0;
        end
        next = 32'(longint'(addr) + imm);
    endfunction

    // Wait (bounded) for the DUT to raise a request, with random stalls.
    task automatic wait_req(output bit got);
        got = 1'b0;
        for (int n = 0; n < 80; n++) begin
            if (mc_req_o === 1'b1) begin
                got = 1'b1;
                break;
            end
            rdy    = ($urandom_range(0, 3) != 0);
            full_i = ($urandom_range(0, 3) == 0);
            tick();
        end
        if (!got) check("req_seen", mc_req_o, 32'd1);
    endtask

    // One complete fetch as seen by the memory controller.
    //   mode bit0: redirect to tgt1 on the first latency cycle (needs lat > 0)
    //   mode bit1: redirect to tgt2 coincident with mc_done_i
    task automatic do_fetch(input logic [31:0] inst, input int lat, input int mode_in,
                            input logic [31:0] tgt1, input logic [31:0] tgt2,
                            input bit hold_full);
        int          mode;
        bit          got;
        logic        bp;
        logic [31:0] nxt;
        mode = (lat == 0) ? (mode_in & 2) : mode_in;
        wait_req(got);
        if (!got) return;
        check("req_addr", mc_addr_o, model_pc);
        for (int i = 0; i < lat; i++) begin
            if (i == 0 && mode[0]) begin
                rdy        = 1'b1;
                clear_i    = 1'b1;
                clear_pc_i = tgt1;
            end else begin
                rdy        = ($urandom_range(0, 3) != 0);
                clear_i    = 1'b0;
                clear_pc_i = $urandom;
            end
            full_i = $urandom_range(0, 1);
            tick();
        end
        rdy        = 1'b1;
        mc_done_i  = 1'b1;
        mc_inst_i  = inst;
        clear_i    = mode[1];
        clear_pc_i = mode[1] ? tgt2 : $urandom;
        tick();
        mc_done_i  = 1'b0;
        clear_i    = 1'b0;
        mc_inst_i  = $urandom;
        full_i     = hold_full;
        rdy        = 1'b1;
        if (mode == 0) begin
            predict(inst, model_pc, bp, nxt);
            sb.push_back('{inst: inst, pc: model_pc, bp: bp});
            model_pc = nxt;
        end else begin
            model_pc = mode[1] ? tgt2 : tgt1;
        end
    endtask

    // Monitor: the queue accepts a write on any edge where we_o and rdy are high.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && rdy && we_o) begin
            if (sb.size() == 0) begin
                check("wr_unexpected", {31'd0, we_o}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("wr_inst", inst_o, e.inst);
                check("wr_pc", pc_o, e.pc);
                check("wr_bp", {31'd0, bp_o}, {31'd0, e.bp});
            end
        end
    end

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: r[6:0] = 7'h6F;
            1: r[6:0] = 7'h63;
            2: r[6:0] = 7'h67;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        bit got;
        checks     = 0;
        errors     = 0;
        model_pc   = RESET_PC;
        rst        = 1'b1;
        rdy        = 1'b1;
        clear_i    = 1'b0;
        clear_pc_i = 32'h0;
        full_i     = 1'b0;
        mc_done_i  = 1'b0;
        mc_inst_i  = 32'h0;

        // Reset
        tick();
        tick();
        check("rst_req", {31'd0, mc_req_o}, 32'd0);
        check("rst_addr", mc_addr_o, 32'h0);
        check("rst_we", {31'd0, we_o}, 32'd0);
        check("rst_inst", inst_o, 32'h0);
        check("rst_pc", pc_o, 32'h0);
        check("rst_bp", {31'd0, bp_o}, 32'd0);
        rst = 1'b0;
        tick();
        check("first_req", {31'd0, mc_req_o}, 32'd1);
        check("first_addr", mc_addr_o, RESET_PC);

        // Sequential fetch, coincident redirect, predictor cases
        do_fetch(NOP,    2, 0, 32'h0, 32'h0,   1'b0);  // 0x00 -> 0x04
        do_fetch(NOP,    1, 0, 32'h0, 32'h0,   1'b0);  // 0x04 -> 0x08
        do_fetch(NOP,    1, 2, 32'h0, 32'h0,   1'b0);  // 0x08 redirected -> 0x00
        do_fetch(JAL16,  0, 0, 32'h0, 32'h0,   1'b0);  // 0x00 -> 0x10
        do_fetch(JAL16,  3, 0, 32'h0, 32'h0,   1'b0);  // 0x10 -> 0x20
        do_fetch(BEQ_M8, 1, 0, 32'h0, 32'h0,   1'b0);  // 0x20 -> 0x18
        do_fetch(JAL8,   2, 0, 32'h0, 32'h0,   1'b0);  // 0x18 -> 0x20
        do_fetch(BEQ_P8, 1, 0, 32'h0, 32'h0,   1'b0);  // 0x20 -> 0x24

        // Full stall: request must wait for full_i to drop, PC unchanged
        do_fetch(NOP, 1, 0, 32'h0, 32'h0, 1'b1);       // 0x24 -> 0x28
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_req", {31'd0, mc_req_o}, 32'd0);
        end
        full_i = 1'b0;
        tick();
        check("stall_release_req", {31'd0, mc_req_o}, 32'd1);
        check("stall_release_addr", mc_addr_o, model_pc);

        // Redirect mid-fetch, coincident redirect, redirect in FLUSH on done
        do_fetch(NOP, 4, 1, 32'h100, 32'h0,   1'b0);
        do_fetch(NOP, 2, 2, 32'h0,   32'h100, 1'b0);
        do_fetch(NOP, 2, 3, 32'h200, 32'h300, 1'b0);

        // Reset with a request outstanding
        wait_req(got);
        rst = 1'b1;
        rdy = 1'b1;
        tick();
        check("midrst_req", {31'd0, mc_req_o}, 32'd0);
        check("midrst_addr", mc_addr_o, 32'h0);
        check("midrst_we", {31'd0, we_o}, 32'd0);
        rst      = 1'b0;
        model_pc = RESET_PC;

        // Randomized fetch stream
        for (int k = 0; k < 200; k++) begin
            int mode;
            mode = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
            do_fetch(rand_inst(), $urandom_range(0, 4), mode,
                     $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, 1'b0);
        end

        full_i = 1'b1;
        rdy    = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
